trap_sequencer: RTL and testbench

Sequences trap entry and exit between the interrupt/fault priority encoder and the CPU control unit. It selects the highest-priority eligible pending trap and requests the CPU with a handshake. It presents the handler vector and tracks handler residency. On handler return it issues a one-hot clear back to the encoder.

---
 rtl/trap_if.sv | 34 +++
 rtl/trap_sequencer.sv | 173 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/trap_if.sv
// trap_if: CPU-side trap handshake between trap_sequencer (master) and the
// CPU control unit (slave).
interface trap_if;
  logic        trap_req;
  logic        trap_ack;
  logic        vector_valid;
  logic [15:0] vector;
  logic [2:0]  cause;
  logic        in_handler;
  logic        is_fault;
  logic        iret;

  modport master (
    output trap_req,
    output vector_valid,
    output vector,
    output cause,
    output in_handler,
    output is_fault,
    input  trap_ack,
    input  iret
  );

  modport slave (
    input  trap_req,
    input  vector_valid,
    input  vector,
    input  cause,
    input  in_handler,
    input  is_fault,
    output trap_ack,
    output iret
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: picks the highest-priority eligible trap, hands it to the CPU,
// tracks handler residency and clears the encoder on return.
// Build macro NESTED_FAULT_EN: lets a fault preempt an interrupt handler one level deep.
module trap_sequencer #(
  parameter logic [15:0] VEC_BASE        = 16'h0100,
  parameter int unsigned VEC_STRIDE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pending,
  input  logic       irq_en,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  trap_if.master     cpu,
  output logic [7:0] clr
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_VEC     = 3'd2,
    ST_HANDLER = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  mask_r;
  logic [7:0]  elig_s;
  logic [2:0]  sel_s;
  logic [2:0]  cause_r;
  logic        trap_req_r;
  logic        vector_valid_r;
  logic [15:0] vector_r;
  logic        in_handler_r;
  logic        is_fault_r;
  logic [7:0]  clr_r;
  logic        unused_mask_s;

`ifdef NESTED_FAULT_EN
  logic        nest_valid_r;
  logic [2:0]  nest_cause_r;
`endif

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] vector_of(input logic [2:0] c);
    logic [15:0] off;
    off = {13'd0, c} << VEC_STRIDE_LOG2;
    return VEC_BASE + off;
  endfunction

  // Eligibility: faults always eligible, interrupts gated by mask and irq_en.
  always_comb begin
    elig_s = {pending[7:2] & mask_r[7:2] & {6{irq_en}}, pending[1:0]};
    sel_s  = lowest_set(elig_s);
  end

  // Fault mask bits are kept for software readback symmetry but never gate anything.
  assign unused_mask_s = ^mask_r[1:0];

  // Mask register; a same-cycle selection sees the previous value.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r <= 8'h00;
    end else if (mask_wr) begin
      mask_r <= mask_data;
    end
  end

  // Trap FSM with all CPU/encoder outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cause_r        <= 3'd0;
      trap_req_r     <= 1'b0;
      vector_valid_r <= 1'b0;
      vector_r       <= 16'h0000;
      in_handler_r   <= 1'b0;
      is_fault_r     <= 1'b0;
      clr_r          <= 8'h00;
`ifdef NESTED_FAULT_EN
      nest_valid_r   <= 1'b0;
      nest_cause_r   <= 3'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          clr_r <= 8'h00;
          if (elig_s != 8'h00) begin
            state_r    <= ST_REQ;
            trap_req_r <= 1'b1;
            cause_r    <= sel_s;
            is_fault_r <= (sel_s < 3'd2);
          end
        end
        ST_REQ: begin
          if (cpu.trap_ack) begin
            state_r        <= ST_VEC;
            trap_req_r     <= 1'b0;
            vector_valid_r <= 1'b1;
            vector_r       <= vector_of(cause_r);
            in_handler_r   <= 1'b1;
          end
        end
        ST_VEC: begin
          vector_valid_r <= 1'b0;
          state_r        <= ST_HANDLER;
        end
        ST_HANDLER: begin
          if (cpu.iret) begin
            state_r      <= ST_DONE;
            clr_r        <= 8'd1 << cause_r;
            in_handler_r <= 1'b0;
          end
`ifdef NESTED_FAULT_EN
          // Only an interrupt handler can be preempted, and only once.
          else if (!nest_valid_r && (cause_r >= 3'd2) && (elig_s[1:0] != 2'b00)) begin
            nest_valid_r <= 1'b1;
            nest_cause_r <= cause_r;
            cause_r      <= elig_s[0] ? 3'd0 : 3'd1;
            is_fault_r   <= 1'b1;
            trap_req_r   <= 1'b1;
            in_handler_r <= 1'b0;
            state_r      <= ST_REQ;
          end
`endif
        end
        ST_DONE: begin
          clr_r <= 8'h00;
`ifdef NESTED_FAULT_EN
          if (nest_valid_r) begin
            state_r      <= ST_HANDLER;
            cause_r      <= nest_cause_r;
            is_fault_r   <= (nest_cause_r < 3'd2);
            in_handler_r <= 1'b1;
            nest_valid_r <= 1'b0;
          end else begin
            state_r    <= ST_IDLE;
            is_fault_r <= 1'b0;
          end
`else
          state_r    <= ST_IDLE;
          is_fault_r <= 1'b0;
`endif
        end
        default: begin
          state_r        <= ST_IDLE;
          trap_req_r     <= 1'b0;
          vector_valid_r <= 1'b0;
          in_handler_r   <= 1'b0;
          is_fault_r     <= 1'b0;
          clr_r          <= 8'h00;
        end
      endcase
    end
  end

  assign cpu.trap_req     = trap_req_r;
  assign cpu.vector_valid = vector_valid_r;
  assign cpu.vector       = vector_r;
  assign cpu.cause        = cause_r;
  assign cpu.in_handler   = in_handler_r;
  assign cpu.is_fault     = is_fault_r;
  assign clr              = clr_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed-vector bench for trap_sequencer; the bench plays
// both the encoder (applies clr to pending) and the CPU (ack / iret).
module tb_trap_sequencer;
  logic       clk;
  logic       reset;
  logic [7:0] pending;
  logic       irq_en;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic [7:0] clr;
  int         n_checks;
  int         n_err;

  trap_if tif ();

  trap_sequencer #(.VEC_BASE(16'h0100), .VEC_STRIDE_LOG2(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .pending   (pending),
    .irq_en    (irq_en),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .cpu       (tif),
    .clr       (clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle; the encoder model applies clr at the end of the cycle it is seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) pending = 8'h00;
    else if (clr != 8'h00) pending = pending & ~clr;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_wr = 1'b1; mask_data = m;
    tick();
    mask_wr = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (tif.trap_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check_eq({tag, ":req"}, {31'd0, tif.trap_req}, 32'd1);
  endtask

  task automatic service(input string tag, input logic [2:0] exp_cause,
                         input logic [15:0] exp_vec, input logic [7:0] exp_clr,
                         input bit poke_ack);
    wait_req(tag);
    check_eq({tag, ":cause"}, {29'd0, tif.cause}, {29'd0, exp_cause});
    check_eq({tag, ":is_fault"}, {31'd0, tif.is_fault}, {31'd0, exp_cause < 3'd2});
    tif.trap_ack = 1'b1;
    tick();
    tif.trap_ack = 1'b0;
    check_eq({tag, ":req_drop"}, {31'd0, tif.trap_req}, 32'd0);
    check_eq({tag, ":vvalid"}, {31'd0, tif.vector_valid}, 32'd1);
    check_eq({tag, ":vector"}, {16'd0, tif.vector}, {16'd0, exp_vec});
    check_eq({tag, ":inh_rise"}, {31'd0, tif.in_handler}, 32'd1);
    tick();
    check_eq({tag, ":vvalid_drop"}, {31'd0, tif.vector_valid}, 32'd0);
    check_eq({tag, ":inh_hold"}, {31'd0, tif.in_handler}, 32'd1);
    if (poke_ack) begin
      tif.trap_ack = 1'b1;
      tick();
      tif.trap_ack = 1'b0;
      check_eq({tag, ":ack_ign_req"}, {31'd0, tif.trap_req}, 32'd0);
      check_eq({tag, ":ack_ign_vv"}, {31'd0, tif.vector_valid}, 32'd0);
      check_eq({tag, ":ack_ign_inh"}, {31'd0, tif.in_handler}, 32'd1);
    end
    tif.iret = 1'b1;
    tick();
    tif.iret = 1'b0;
    check_eq({tag, ":clr"}, {24'd0, clr}, {24'd0, exp_clr});
    check_eq({tag, ":inh_drop"}, {31'd0, tif.in_handler}, 32'd0);
    tick();
    check_eq({tag, ":clr_once"}, {24'd0, clr}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ":req"}, {31'd0, tif.trap_req}, 32'd0);
    check_eq({tag, ":vv"}, {31'd0, tif.vector_valid}, 32'd0);
    check_eq({tag, ":vector"}, {16'd0, tif.vector}, 32'd0);
    check_eq({tag, ":cause"}, {29'd0, tif.cause}, 32'd0);
    check_eq({tag, ":inh"}, {31'd0, tif.in_handler}, 32'd0);
    check_eq({tag, ":fault"}, {31'd0, tif.is_fault}, 32'd0);
    check_eq({tag, ":clr"}, {24'd0, clr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_err = 0;
    clk = 1'b0; reset = 1'b1; pending = 8'h00; irq_en = 1'b0;
    mask_wr = 1'b0; mask_data = 8'h00;
    tif.trap_ack = 1'b0; tif.iret = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Masked interrupt is not taken; mask write makes it eligible two cycles later.
    irq_en = 1'b1; pending = 8'h04;
    tick(); tick(); tick();
    check_eq("masked:req", {31'd0, tif.trap_req}, 32'd0);
    mask_wr = 1'b1; mask_data = 8'h04;
    tick();
    mask_wr = 1'b0;
    check_eq("mask_wr+1:req", {31'd0, tif.trap_req}, 32'd0);
    tick();
    check_eq("mask_wr+2:req", {31'd0, tif.trap_req}, 32'd1);
    service("t1", 3'd2, 16'h0108, 8'h04, 1'b0);

    // Two faults: bit0 first, then bit1 after the encoder clears bit0.
    pending = 8'h03;
    service("t2a", 3'd0, 16'h0100, 8'h01, 1'b0);
    service("t2b", 3'd1, 16'h0104, 8'h02, 1'b0);

    // Faults ignore irq_en and mask.
    irq_en = 1'b0;
    write_mask(8'h00);
    pending = 8'h01;
    service("t3", 3'd0, 16'h0100, 8'h01, 1'b0);

    // Priority among interrupts; stray trap_ack in the handler is ignored.
    irq_en = 1'b1;
    write_mask(8'hFF);
    pending = 8'h24;
    service("t4a", 3'd2, 16'h0108, 8'h04, 1'b1);
    service("t4b", 3'd5, 16'h0114, 8'h20, 1'b0);

    // Reset while in the handler: everything returns to zero, no clr ever issues.
    pending = 8'h08;
    wait_req("t5");
    tif.trap_ack = 1'b1;
    tick();
    tif.trap_ack = 1'b0;
    tick();
    check_eq("t5:in_handler", {31'd0, tif.in_handler}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t5_rst");
    tif.iret = 1'b1;
    tick();
    tif.iret = 1'b0;
    check_eq("t5:clr_a", {24'd0, clr}, 32'd0);
    tick();
    check_eq("t5:clr_b", {24'd0, clr}, 32'd0);
    check_eq("t5:req", {31'd0, tif.trap_req}, 32'd0);

    // Fault raised during an interrupt handler (cause 3); reset cleared the mask.
    write_mask(8'hFF);
    pending = 8'h08;
    service("t6pre", 3'd3, 16'h010C, 8'h08, 1'b0);
    pending = 8'h08;
    wait_req("t6");
    check_eq("t6:cause", {29'd0, tif.cause}, 32'd3);
    tif.trap_ack = 1'b1;
    tick();
    tif.trap_ack = 1'b0;
    tick();
    pending = pending | 8'h02;
`ifdef NESTED_FAULT_EN
    tick();
    check_eq("nest:req", {31'd0, tif.trap_req}, 32'd1);
    check_eq("nest:cause", {29'd0, tif.cause}, 32'd1);
    check_eq("nest:is_fault", {31'd0, tif.is_fault}, 32'd1);
    check_eq("nest:inh", {31'd0, tif.in_handler}, 32'd0);
    tif.trap_ack = 1'b1;
    tick();
    tif.trap_ack = 1'b0;
    check_eq("nest:vv", {31'd0, tif.vector_valid}, 32'd1);
    check_eq("nest:vector", {16'd0, tif.vector}, 32'h0104);
    tick();
    tif.iret = 1'b1;
    tick();
    tif.iret = 1'b0;
    check_eq("nest:clr_fault", {24'd0, clr}, 32'h02);
    check_eq("nest:inh_drop", {31'd0, tif.in_handler}, 32'd0);
    tick();
    check_eq("nest:inh_back", {31'd0, tif.in_handler}, 32'd1);
    check_eq("nest:cause_back", {29'd0, tif.cause}, 32'd3);
    check_eq("nest:no_vv", {31'd0, tif.vector_valid}, 32'd0);
    check_eq("nest:fault_back", {31'd0, tif.is_fault}, 32'd0);
    tif.iret = 1'b1;
    tick();
    tif.iret = 1'b0;
    check_eq("nest:clr_outer", {24'd0, clr}, 32'h08);
    tick();
`else
    tick();
    tick();
    check_eq("defer:req", {31'd0, tif.trap_req}, 32'd0);
    check_eq("defer:inh", {31'd0, tif.in_handler}, 32'd1);
    check_eq("defer:cause", {29'd0, tif.cause}, 32'd3);
    tif.iret = 1'b1;
    tick();
    tif.iret = 1'b0;
    check_eq("defer:clr_outer", {24'd0, clr}, 32'h08);
    tick();
    service("defer", 3'd1, 16'h0104, 8'h02, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
